// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier: state
// encoding and sizing helpers for the iteration and shift counters.
package mult_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_RUN  = 1'b1;

  // Worst-case number of RUN iterations for a full-width multiplier operand.
  function automatic int iter_count(input int width, input int step);
    return (width + step - 1) / step;
  endfunction

  // Cycles from the accepting edge to done for a full-width multiplier.
  function automatic int max_latency(input int width, input int step);
    return 1 + iter_count(width, step);
  endfunction

  // Shift counter width; the largest shift applied is WIDTH-STEP.
  function automatic int shift_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_radix_step.sv
// One radix-2^STEP iteration: adds (digit * mag1) << shift into the
// running product. Keeps the STEP-dependent adder tree in one place.
module mult_radix_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int PW    = 64,
  parameter int SW    = 5
) (
  input  logic [STEP-1:0]  digit,
  input  logic [WIDTH-1:0] mag1,
  input  logic [SW-1:0]    shift,
  input  logic [PW-1:0]    prod,
  output logic [PW-1:0]    prod_next
);

  localparam int PPW = WIDTH + STEP;

  logic [PPW-1:0] pp;
  logic [PW-1:0]  pp_ext;

  assign pp        = PPW'(mag1) * PPW'(digit);
  // In the short datapath PW < PPW; the truncation is the intended mod 2^WIDTH.
  assign pp_ext    = PW'(pp);
  assign prod_next = prod + (pp_ext << shift);

endmodule

// File: rtl/iter_multiplier.sv
// Iterative shift-and-add multiply-accumulate with early termination.
// Define MULT_LONG_EN to enable the 2*WIDTH long (signed/unsigned) mode.
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 long_mode,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic [2*WIDTH-1:0]   acc0,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 res_n,
  output logic                 res_z
);

`ifdef MULT_LONG_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int SW = shift_w(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mag0_q, mag0_d;
  logic [WIDTH-1:0]   mag1_q, mag1_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               res_n_q, res_n_d;
  logic               res_z_q, res_z_d;

  logic [PW-1:0]      prod_step;
  logic [PW-1:0]      prod_signed;
  logic [PW-1:0]      sum;

`ifdef MULT_LONG_EN
  logic neg_q, neg_d;
  logic long_q, long_d;
  logic sgn_req;

  // Signed only matters for long results; short low bits are sign-agnostic.
  assign sgn_req     = long_mode & signed_mode;
  assign prod_signed = neg_q ? -prod_q : prod_q;
`else
  logic unused_long_inputs;

  assign unused_long_inputs = &{1'b0, long_mode, signed_mode, acc0[2*WIDTH-1:WIDTH]};
  assign prod_signed        = prod_q;
`endif

  assign sum = acc_q + prod_signed;

  mult_radix_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .PW    (PW),
    .SW    (SW)
  ) u_step (
    .digit     (mag0_q[STEP-1:0]),
    .mag1      (mag1_q),
    .shift     (shift_q),
    .prod      (prod_q),
    .prod_next (prod_step)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mag0_d   = mag0_q;
    mag1_d   = mag1_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    result_d = result_q;
    res_n_d  = res_n_q;
    res_z_d  = res_z_q;
`ifdef MULT_LONG_EN
    neg_d    = neg_q;
    long_d   = long_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
`ifdef MULT_LONG_EN
          // Unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) for the most-negative operand.
          mag0_d = (sgn_req && in0[WIDTH-1]) ? -in0 : in0;
          mag1_d = (sgn_req && in1[WIDTH-1]) ? -in1 : in1;
          neg_d  = sgn_req & (in0[WIDTH-1] ^ in1[WIDTH-1]);
          long_d = long_mode;
          acc_d  = long_mode ? acc0 : {{WIDTH{1'b0}}, acc0[WIDTH-1:0]};
`else
          mag0_d = in0;
          mag1_d = in1;
          acc_d  = acc0[WIDTH-1:0];
`endif
          prod_d  = '0;
          shift_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (mag0_q != '0) begin
          prod_d  = prod_step;
          mag0_d  = mag0_q >> STEP;
          shift_d = shift_q + SW'(STEP);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef MULT_LONG_EN
          if (long_q) begin
            result_d = sum;
            res_n_d  = sum[2*WIDTH-1];
            res_z_d  = (sum == '0);
          end else begin
            result_d = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            res_n_d  = sum[WIDTH-1];
            res_z_d  = (sum[WIDTH-1:0] == '0);
          end
`else
          result_d = {{WIDTH{1'b0}}, sum};
          res_n_d  = sum[WIDTH-1];
          res_z_d  = (sum == '0);
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mag0_q   <= '0;
      mag1_q   <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      res_n_q  <= 1'b0;
      res_z_q  <= 1'b1;
`ifdef MULT_LONG_EN
      neg_q    <= 1'b0;
      long_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mag0_q   <= mag0_d;
      mag1_q   <= mag1_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      result_q <= result_d;
      res_n_q  <= res_n_d;
      res_z_q  <= res_z_d;
`ifdef MULT_LONG_EN
      neg_q    <= neg_d;
      long_q   <= long_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign res_n  = res_n_q;
  assign res_z  = res_z_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier (WIDTH=32, STEP=2); long-mode vectors
// run only when MULT_LONG_EN is defined.
module tb_iter_multiplier;
  import mult_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        long_mode;
  logic        signed_mode;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [63:0] acc0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        res_n;
  logic        res_z;

  iter_multiplier #(.WIDTH(32), .STEP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .long_mode   (long_mode),
    .signed_mode (signed_mode),
    .in0         (in0),
    .in1         (in1),
    .acc0        (acc0),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .res_n       (res_n),
    .res_z       (res_z)
  );

  typedef struct {
    logic [63:0] res;
    logic        n;
    logic        z;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [63:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e.res);
        check("res_n", {63'b0, res_n}, {63'b0, mon_e.n});
        check("res_z", {63'b0, res_z}, {63'b0, mon_e.z});
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
        last_res = mon_e.res;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                       input logic lm, input logic sm, input bit push,
                       input logic [63:0] er, input logic en, input logic ez, input int lat);
    exp_t e;
    in0 = a; in1 = b; acc0 = acc; long_mode = lm; signed_mode = sm; start = 1'b1;
    if (push) begin
      e.res = er; e.n = en; e.z = ez; e.lat = lat; e.start_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in0 = $urandom; in1 = $urandom; acc0 = {$urandom, $urandom};
    long_mode = 1'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 * max_latency(32, 2) && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; long_mode = 1'b0; signed_mode = 1'b0;
    in0 = '0; in1 = '0; acc0 = '0;
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_res_n", {63'b0, res_n}, 64'd0);
    check("rst_res_z", {63'b0, res_z}, 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Short-mode directed vectors.
    issue(32'd3, 32'd5, 64'd0, 0, 0, 1, 64'd15, 0, 0, 2);
    drain("drain_3x5");
    issue(32'd0, 32'h1234, 64'd7, 0, 0, 1, 64'd7, 0, 0, 1);
    drain("drain_zero_mult");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, 0, 1, 64'd2, 0, 0, 17);
    drain("drain_max_short");
    issue(32'h8000_0000, 32'd1, 64'd0, 0, 0, 1, 64'h0000_0000_8000_0000, 1, 0, 17);
    drain("drain_neg_flag");
    issue(32'd2, 32'h8000_0000, 64'd0, 0, 0, 1, 64'd0, 0, 1, 2);
    drain("drain_zero_flag");
    issue(32'd4, 32'd6, 64'hDEAD_0000_0000_0005, 0, 0, 1, 64'd29, 0, 0, 3);
    drain("drain_acc_upper");
    issue(32'd5, 32'd7, 64'h100, 0, 0, 1, 64'd291, 0, 0, 3);
    drain("drain_5x7");
`ifndef MULT_LONG_EN
    issue(32'hFFFF_FFFE, 32'd3, 64'd0, 1, 1, 1, 64'h0000_0000_FFFF_FFFA, 1, 0, 17);
    drain("drain_long_ignored");
`endif

    // Start accepted in the same cycle as done.
    issue(32'd3, 32'd5, 64'd0, 0, 0, 1, 64'd15, 0, 0, 2);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("b2b_done_seen", {63'b0, done}, 64'd1);
    issue(32'd1, 32'h20, 64'd0, 0, 0, 1, 64'h20, 0, 0, 2);
    drain("drain_b2b");

    // Abort on the third RUN cycle.
    issue(32'hFFFF_0000, 32'd3, 64'd0, 0, 0, 0, '0, 0, 0, 0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_result_kept", result, last_res);
    issue(32'd3, 32'd5, 64'd0, 0, 0, 1, 64'd15, 0, 0, 2);
    drain("drain_after_abort");

    // Abort wins over completion on the same edge.
    issue(32'd1, 32'd9, 64'd0, 0, 0, 0, '0, 0, 0, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_prio_busy", {63'b0, busy}, 64'd0);
    check("abort_prio_result", result, last_res);
    repeat (3) @(negedge clk);

    // Abort in IDLE blocks a same-cycle start.
    in0 = 32'd3; in1 = 32'd5; acc0 = '0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_blocks_start", {63'b0, busy}, 64'd0);
    repeat (4) @(negedge clk);

    // Start while busy is dropped, not queued.
    issue(32'h0000_FFFF, 32'd2, 64'd0, 0, 0, 1, 64'h0001_FFFE, 0, 0, 9);
    repeat (2) @(negedge clk);
    check("busy_midrun", {63'b0, busy}, 64'd1);
    in0 = 32'd3; in1 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("drain_busy_start");
    repeat (5) @(negedge clk);

`ifdef MULT_LONG_EN
    issue(32'hFFFF_FFFE, 32'd3, 64'd0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFA, 1, 0, 2);
    drain("drain_long_signed");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 0, 1, 64'hFFFF_FFFE_0000_0001, 1, 0, 17);
    drain("drain_long_unsigned");
    issue(32'h8000_0000, 32'h8000_0000, 64'd0, 1, 1, 1, 64'h4000_0000_0000_0000, 0, 0, 17);
    drain("drain_long_minneg");
    issue(32'd3, 32'hFFFF_FFFF, 64'h10, 1, 1, 1, 64'd13, 0, 0, 2);
    drain("drain_long_mla");
    issue(32'hFFFF_FFFF, 32'd5, 64'd5, 1, 1, 1, 64'd0, 0, 1, 2);
    drain("drain_long_zero");
`endif

    // Reset mid-operation: outputs at reset values immediately, no done.
    issue(32'hFFFF_FFFF, 32'd7, 64'd0, 0, 0, 0, '0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_res_n", {63'b0, res_n}, 64'd0);
    check("midrst_res_z", {63'b0, res_z}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {63'b0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/iter_multiplier.md
# iter_multiplier

Parametrised iterative shift-and-add multiplier for the Execute stage, the successor to the fixed 32-bit radix-4 unit. It computes `acc0 + in0*in1` over a variable number of cycles with early termination on the multiplier operand. It adds a full-width long result (signed/unsigned), an explicit busy/done handshake, abort on pipeline flush, and N/Z flag outputs for CPSR update.

## Interface
- `WIDTH`, 32: operand width; must be divisible by `STEP`.
- `STEP`, 2: multiplier bits consumed per cycle; legal values 1, 2, 4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `abort` in 1: cancel the operation in flight (pipeline flush).
- `long_mode` in 1: 1 = 2·WIDTH-bit result (UMULL/SMULL/UMLAL/SMLAL class).
- `signed_mode` in 1: 1 = signed operands; meaningful only when `long_mode`=1.
- `in0` in WIDTH: multiplier (Rm); drives iteration count.
- `in1` in WIDTH: multiplicand (Rs).
- `acc0` in 2·WIDTH: accumulate addend; upper half ignored when `long_mode`=0.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; `result` valid from this cycle.
- `result` out 2·WIDTH: product plus accumulator; held until the next `done`.
- `res_n` out 1: sign bit of the result (bit WIDTH-1 in short mode, bit 2·WIDTH-1 in long mode).
- `res_z` out 1: active result bits all zero.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating.
  - The done cycle is the RUN→IDLE transition edge; it has no separate state.
- IDLE, on `start`=1:
  - Latch `mag0`=|in0| and `mag1`=|in1|. Take absolute values only when long and signed; otherwise latch the raw operands.
  - Latch `neg` = sign0 XOR sign1 (long signed only; else 0), `acc0`, and the mode bits.
  - Clear `prod` (2·WIDTH bits).
  - Set `busy`=1 and go to RUN.
- RUN edge, `mag0`≠0:
  - `prod += (mag0[STEP-1:0] · mag1) << shift`.
  - `mag0 >>= STEP`.
  - `shift += STEP`.
- RUN edge, `mag0`=0:
  - `result = acc0 + (neg ? -prod : prod)`, modulo 2^(2·WIDTH).
  - In short mode the upper WIDTH bits of `result` are forced to 0.
  - Update `res_n`/`res_z`, pulse `done`=1, set `busy`=0, return to IDLE.
- Short mode signed and unsigned produce identical low bits, so `signed_mode` is ignored there.
- `abort`=1 in RUN: return to IDLE next edge, `busy`=0, no `done`, `result` unchanged. `abort` has priority over completion on the same edge. In IDLE `abort` is ignored, and it also blocks a same-cycle `start`.
- `start` while `busy`=1 is ignored; it is not queued.
- Most-negative operand: the magnitude is 2^(WIDTH-1) and must be held as unsigned without overflow.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `res_n`=0, `res_z`=1, state IDLE. A reset mid-operation discards the operation with no `done`.
- Latency from the `start` edge to `done` high = 1 + ceil(nbits/STEP), where nbits = index of the highest set bit of the latched `mag0` plus 1 (0 if zero).
  - Minimum: 1 cycle (`in0`=0).
  - Maximum: 1 + WIDTH/STEP (17 for 32/2).
- `start` is accepted in the same cycle that `done` pulses, because `busy` is already 0 in that cycle.
- Inputs are sampled only on the accepting edge. Operands may change afterwards without effect.

## Configuration
- `MULT_LONG_EN` defined:
  - `long_mode` and `signed_mode` are honoured.
  - `prod` and `acc` are 2·WIDTH bits wide.
- `MULT_LONG_EN` undefined:
  - `long_mode` and `signed_mode` are ignored and treated as 0.
  - Internal datapath is WIDTH bits; `result[2·WIDTH-1:WIDTH]` is tied to 0.
  - Port list is unchanged.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum (IDLE, RUN);
  - localparam helpers for the iteration count and shift-counter width, clog2(WIDTH).
- Optional sub-module `mult_radix_step` (combinational): partial product `mag0[STEP-1:0]·mag1`, shifted and summed into `prod`. It isolates the STEP-dependent adder tree.
- Everything else lives in the top module.

## Test plan
- WIDTH=32, STEP=2, short, `in0`=3, `in1`=5, `acc0`=0 → `done` 2 cycles after start, `result`=15, `res_n`=0, `res_z`=0.
- `in0`=0, `in1`=0x1234, `acc0`=7 → `done` 1 cycle after start, `result`=7.
- Short, `in0`=`in1`=0xFFFFFFFF, `acc0`=1 → `done` after 17 cycles, `result`=0x0000000000000002, `res_n`=0.
- `MULT_LONG_EN`, long signed, `in0`=0xFFFFFFFE (-2), `in1`=3, `acc0`=0 → `result`=0xFFFFFFFFFFFFFFFA, `res_n`=1. Unsigned long 0xFFFFFFFF² → 0xFFFFFFFE00000001.
- `in0`=0xFFFF0000 started, then `abort` on the 3rd RUN cycle → `busy`=0 next cycle, no `done`, previous `result` retained. An immediate new start of 3·5 yields 15.
- `start` pulsed while `busy` → ignored, original result delivered. `rst` asserted mid-RUN → all outputs at reset values at once, no `done`.
